// File: rtl/cal_pkg.sv
// Shared types and constants for the calendar set-time controller.
package cal_pkg;

  localparam int TIME_W = 6;

  localparam logic [TIME_W-1:0] HOUR_MAX = 6'd23;
  localparam logic [TIME_W-1:0] MIN_MAX  = 6'd59;
  localparam logic [TIME_W-1:0] SEC_MAX  = 6'd59;

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    SET_HR  = 3'd1,
    SET_MIN = 3'd2,
    SET_SEC = 3'd3,
    COMMIT  = 3'd4
  } cal_state_e;

  typedef enum logic [1:0] {
    FIELD_NONE = 2'd0,
    FIELD_HR   = 2'd1,
    FIELD_MIN  = 2'd2,
    FIELD_SEC  = 2'd3
  } cal_field_e;

  // Anything captured at or beyond the field maximum rolls to zero.
  function automatic logic [TIME_W-1:0] wrap_inc(input logic [TIME_W-1:0] val,
                                                 input logic [TIME_W-1:0] max_val);
    logic [TIME_W-1:0] res;
    if (val >= max_val) begin
      res = 6'd0;
    end else begin
      res = val + 6'd1;
    end
    return res;
  endfunction

  function automatic cal_field_e field_of(input cal_state_e st);
    cal_field_e res;
    case (st)
      SET_HR:  res = FIELD_HR;
      SET_MIN: res = FIELD_MIN;
      SET_SEC: res = FIELD_SEC;
      default: res = FIELD_NONE;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cal_prescaler.sv
// Divide-by-DIV counter with synchronous clear/hold; wrap is high on the
// cycle the counter sits at DIV-1 (the caller registers it).
module cal_prescaler #(
  parameter int DIV = 4,
  parameter int W   = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  output logic wrap
);

  localparam logic [W-1:0] TOP_C = W'(DIV - 1);

  logic [W-1:0] cnt_r;

  assign wrap = !clr && (cnt_r == TOP_C);

  // Count 0..DIV-1, held at zero while cleared.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_r <= {W{1'b0}};
    end else if (clr || wrap) begin
      cnt_r <= {W{1'b0}};
    end else begin
      cnt_r <= cnt_r + W'(1);
    end
  end

endmodule

// File: rtl/calendar_set_ctrl.sv
// Set-time controller: 1 Hz tick prescaler, edit FSM with shadow fields and
// one-cycle parallel load. Optional edit-field blink via CAL_SET_CTRL_BLINK_EN.
module calendar_set_ctrl
  import cal_pkg::*;
#(
  parameter int TICK_DIV  = 50000000,
  parameter int BLINK_DIV = 12500000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Mode_btn,
  input  logic              Inc_btn,
  input  logic [TIME_W-1:0] Cur_hours,
  input  logic [TIME_W-1:0] Cur_mins,
  input  logic [TIME_W-1:0] Cur_secs,
  output logic              Tick_en,
  output logic              Load,
  output logic [TIME_W-1:0] Load_hours,
  output logic [TIME_W-1:0] Load_mins,
  output logic [TIME_W-1:0] Load_secs,
  output logic [1:0]        Set_field,
  output logic              Blink
);

  cal_state_e        state_r, state_nxt_s;
  cal_field_e        field_r;
  logic [TIME_W-1:0] hr_r, min_r, sec_r;
  logic [TIME_W-1:0] load_hr_r, load_min_r, load_sec_r;
  logic              tick_r, load_r;
  logic              tick_clr_s, tick_wrap_s;

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      RUN: begin
        if (Mode_btn) state_nxt_s = SET_HR;
        else          state_nxt_s = RUN;
      end
      SET_HR: begin
        if (Mode_btn) state_nxt_s = SET_MIN;
        else          state_nxt_s = SET_HR;
      end
      SET_MIN: begin
        if (Mode_btn) state_nxt_s = SET_SEC;
        else          state_nxt_s = SET_MIN;
      end
      SET_SEC: begin
        if (Mode_btn) state_nxt_s = COMMIT;
        else          state_nxt_s = SET_SEC;
      end
      COMMIT:  state_nxt_s = RUN;
      default: state_nxt_s = RUN;
    endcase
  end

  // Hold the prescaler on both edges of an edit so no tick leaks out of RUN.
  assign tick_clr_s = (state_r != RUN) || (state_nxt_s != RUN);

  cal_prescaler #(.DIV(TICK_DIV)) u_tick_div (
    .CLK  (CLK),
    .RST  (RST),
    .clr  (tick_clr_s),
    .wrap (tick_wrap_s)
  );

  // State register and registered outputs, decoded from the next state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r    <= RUN;
      field_r    <= FIELD_NONE;
      tick_r     <= 1'b0;
      load_r     <= 1'b0;
      load_hr_r  <= 6'd0;
      load_min_r <= 6'd0;
      load_sec_r <= 6'd0;
    end else begin
      state_r <= state_nxt_s;
      field_r <= field_of(state_nxt_s);
      tick_r  <= tick_wrap_s;
      load_r  <= (state_nxt_s == COMMIT);
      if (state_nxt_s == COMMIT) begin
        load_hr_r  <= hr_r;
        load_min_r <= min_r;
        load_sec_r <= sec_r;
      end else begin
        load_hr_r  <= 6'd0;
        load_min_r <= 6'd0;
        load_sec_r <= 6'd0;
      end
    end
  end

  // Shadow fields: captured on entry to edit, bumped by Inc unless Mode also fires.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hr_r  <= 6'd0;
      min_r <= 6'd0;
      sec_r <= 6'd0;
    end else if ((state_r == RUN) && Mode_btn) begin
      hr_r  <= Cur_hours;
      min_r <= Cur_mins;
      sec_r <= Cur_secs;
    end else if (Inc_btn && !Mode_btn) begin
      case (state_r)
        SET_HR:  hr_r  <= wrap_inc(hr_r, HOUR_MAX);
        SET_MIN: min_r <= wrap_inc(min_r, MIN_MAX);
        SET_SEC: sec_r <= wrap_inc(sec_r, SEC_MAX);
        default: begin
          hr_r  <= hr_r;
          min_r <= min_r;
          sec_r <= sec_r;
        end
      endcase
    end else begin
      hr_r  <= hr_r;
      min_r <= min_r;
      sec_r <= sec_r;
    end
  end

  assign Tick_en    = tick_r;
  assign Load       = load_r;
  assign Load_hours = load_hr_r;
  assign Load_mins  = load_min_r;
  assign Load_secs  = load_sec_r;
  assign Set_field  = field_r;

`ifdef CAL_SET_CTRL_BLINK_EN
  logic blink_r, blink_clr_s, blink_wrap_s;

  // Restart the blink phase on every entry into a SET state.
  assign blink_clr_s = (field_of(state_nxt_s) == FIELD_NONE) || (state_nxt_s != state_r);

  cal_prescaler #(.DIV(BLINK_DIV)) u_blink_div (
    .CLK  (CLK),
    .RST  (RST),
    .clr  (blink_clr_s),
    .wrap (blink_wrap_s)
  );

  // Blink phase toggles on each blink-counter wrap.
  always_ff @(posedge CLK) begin
    if (RST) begin
      blink_r <= 1'b0;
    end else if (blink_clr_s) begin
      blink_r <= 1'b0;
    end else if (blink_wrap_s) begin
      blink_r <= ~blink_r;
    end else begin
      blink_r <= blink_r;
    end
  end

  assign Blink = blink_r;
`else
  // No blink hardware in this build; BLINK_DIV is kept for a uniform parameter list.
  localparam bit BLINK_DIV_SET_C = (BLINK_DIV != 0);
  assign Blink = BLINK_DIV_SET_C & 1'b0;
`endif

endmodule

// File: tb/tb_calendar_set_ctrl.sv
// Self-checking bench for calendar_set_ctrl: behavioural model plus directed and random stimulus.
module tb_calendar_set_ctrl;

  localparam int TD = 4;
  localparam int BD = 3;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       Mode_btn = 1'b0;
  logic       Inc_btn = 1'b0;
  logic [5:0] Cur_hours = 6'd0;
  logic [5:0] Cur_mins = 6'd0;
  logic [5:0] Cur_secs = 6'd0;
  logic       Tick_en, Load, Blink;
  logic [5:0] Load_hours, Load_mins, Load_secs;
  logic [1:0] Set_field;

  always #5 CLK = ~CLK;

  calendar_set_ctrl #(.TICK_DIV(TD), .BLINK_DIV(BD)) dut (
    .CLK(CLK), .RST(RST), .Mode_btn(Mode_btn), .Inc_btn(Inc_btn),
    .Cur_hours(Cur_hours), .Cur_mins(Cur_mins), .Cur_secs(Cur_secs),
    .Tick_en(Tick_en), .Load(Load), .Load_hours(Load_hours),
    .Load_mins(Load_mins), .Load_secs(Load_secs),
    .Set_field(Set_field), .Blink(Blink)
  );

  int errors = 0;
  int checks = 0;

  // Model: mode 0=run, 1..3 = editing hours/mins/secs, 4 = commit.
  int m_mode = 0, m_h = 0, m_m = 0, m_s = 0;
  int run_len = 0, set_len = 0;
  int e_tick = 0, e_load = 0, e_field = 0, e_blink = 0;

  int tick_seen = 0, load_seen = 0;
  int last_h = -1, last_m = -1, last_s = -1;
  bit chk_en = 1'b0;

  function automatic int inc_f(input int v, input int mx);
    return (v >= mx) ? 0 : v + 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit m, input bit i, input bit r);
    int prev;
    int nxt;
    if (r) begin
      m_mode = 0; m_h = 0; m_m = 0; m_s = 0;
      run_len = 0; set_len = 0;
      e_tick = 0; e_load = 0; e_field = 0; e_blink = 0;
    end else begin
      prev = m_mode;
      if (prev == 0)      nxt = m ? 1 : 0;
      else if (prev == 4) nxt = 0;
      else                nxt = m ? prev + 1 : prev;
      if (prev == 0 && m) begin
        m_h = int'(Cur_hours); m_m = int'(Cur_mins); m_s = int'(Cur_secs);
      end
      if (prev >= 1 && prev <= 3 && !m && i) begin
        if (prev == 1)      m_h = inc_f(m_h, 23);
        else if (prev == 2) m_m = inc_f(m_m, 59);
        else                m_s = inc_f(m_s, 59);
      end
      e_load  = (nxt == 4) ? 1 : 0;
      e_field = (nxt >= 1 && nxt <= 3) ? nxt : 0;
      if (nxt == 0) begin
        run_len = (prev == 0) ? run_len + 1 : 0;
        e_tick  = (run_len > 0 && run_len % TD == 0) ? 1 : 0;
      end else begin
        run_len = 0;
        e_tick  = 0;
      end
      if (nxt >= 1 && nxt <= 3) begin
        set_len = (prev == nxt) ? set_len + 1 : 0;
`ifdef CAL_SET_CTRL_BLINK_EN
        e_blink = (set_len / BD) % 2;
`else
        e_blink = 0;
`endif
      end else begin
        set_len = 0;
        e_blink = 0;
      end
      m_mode = nxt;
    end
  endtask

  task automatic step(input bit m, input bit i, input bit r);
    Mode_btn = m; Inc_btn = i; RST = r;
    @(posedge CLK);
    model_edge(m, i, r);
    #1;
    Mode_btn = 1'b0; Inc_btn = 1'b0; RST = 1'b0;
  endtask

  task automatic settle();
    @(negedge CLK);
    #1;
  endtask

  // Single compare process: every output against the model each cycle.
  always @(negedge CLK) begin
    if (chk_en) begin
      check("tick_en", {31'd0, Tick_en}, e_tick);
      check("load", {31'd0, Load}, e_load);
      if (e_load != 0) begin
        check("load_hours", {26'd0, Load_hours}, m_h);
        check("load_mins", {26'd0, Load_mins}, m_m);
        check("load_secs", {26'd0, Load_secs}, m_s);
      end
      check("set_field", {30'd0, Set_field}, e_field);
      check("blink", {31'd0, Blink}, e_blink);
      if (Tick_en === 1'b1) tick_seen++;
      if (Load === 1'b1) begin
        load_seen++;
        last_h = int'(Load_hours); last_m = int'(Load_mins); last_s = int'(Load_secs);
      end
    end
  end

  initial begin
    step(1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    tick_seen = 0; load_seen = 0;

    // Idle run: five ticks in twenty cycles, no loads.
    repeat (20) step(1'b0, 1'b0, 1'b0);
    settle();
    check("idle_ticks", tick_seen, 5);
    check("idle_loads", load_seen, 0);

    // 10:20:30 edited to 12:21:30.
    Cur_hours = 6'd10; Cur_mins = 6'd20; Cur_secs = 6'd30;
    step(1, 0, 0); step(0, 1, 0); step(0, 1, 0); step(1, 0, 0);
    step(0, 1, 0); step(1, 0, 0); step(1, 0, 0); step(0, 0, 0);
    settle();
    check("edit_load_cnt", load_seen, 1);
    check("edit_h", last_h, 12);
    check("edit_m", last_m, 21);
    check("edit_s", last_s, 30);

    // Every field wraps from its maximum.
    Cur_hours = 6'd23; Cur_mins = 6'd59; Cur_secs = 6'd59;
    step(1, 0, 0); step(0, 1, 0); step(1, 0, 0); step(0, 1, 0);
    step(1, 0, 0); step(0, 1, 0); step(1, 0, 0); step(0, 0, 0);
    settle();
    check("wrap_load_cnt", load_seen, 2);
    check("wrap_h", last_h, 0);
    check("wrap_m", last_m, 0);
    check("wrap_s", last_s, 0);

    // Mode and Inc together in SET_MIN: Mode wins, minutes unchanged.
    Cur_hours = 6'd5; Cur_mins = 6'd30; Cur_secs = 6'd45;
    step(1, 0, 0); step(1, 0, 0); step(1, 1, 0);
    settle();
    check("both_field", {30'd0, Set_field}, 3);
    step(1, 0, 0); step(0, 0, 0);
    settle();
    check("both_load_cnt", load_seen, 3);
    check("both_m", last_m, 30);

    // Reset during SET_SEC: no load, prescaler restarts.
    step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
    step(0, 0, 1);
    tick_seen = 0;
    repeat (10) step(0, 0, 0);
    settle();
    check("rst_edit_loads", load_seen, 3);
    check("rst_edit_ticks", tick_seen, 2);
    check("rst_edit_field", {30'd0, Set_field}, 0);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        Cur_hours = 6'($urandom_range(0, 63));
        Cur_mins  = 6'($urandom_range(0, 63));
        Cur_secs  = 6'($urandom_range(0, 63));
      end else begin
        Cur_hours = 6'($urandom_range(0, 23));
        Cur_mins  = 6'($urandom_range(0, 59));
        Cur_secs  = 6'($urandom_range(0, 59));
      end
      step($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 299) == 0);
    end
    settle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
